ccsds_asm_randomizer: RTL and testbench



---
 rtl/ccsds_tm_pkg.sv | 19 +
 rtl/ccsds_prn_lfsr.sv | 37 +++
 rtl/ccsds_asm_randomizer.sv | 135 +++++++++++++
 tb/tb_ccsds_asm_randomizer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccsds_tm_pkg.sv
// Shared constants and state encoding for the CCSDS TM sync/randomizer path.
// ASM default, LDPC codeblock length, PRN seed/taps, one-hot FSM states.
package ccsds_tm_pkg;

    localparam logic [31:0] ASM_WORD_DEFAULT    = 32'h1ACFFC1D;
    localparam int          BLOCK_LEN_LDPC_8160 = 8160;

    // Window r[7] is the current PRN bit, r[0] the newest. The feedback
    // taps realise h(x)=x^8+x^7+x^5+x^3+1.
    localparam logic [7:0]  PRN_SEED = 8'hFF;
    localparam logic [7:0]  PRN_TAPS = 8'b1001_0101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_ASM  = 3'b010,
        ST_DATA = 3'b100
    } state_e;

endpackage

// File: rtl/ccsds_prn_lfsr.sv
// CCSDS pseudo-randomizer sequence generator, period 255, seed all ones.
// Emits FF 48 0E C0 ... MSB first, one bit per advance.
module ccsds_prn_lfsr
    import ccsds_tm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic init,
    input  logic advance,
    output logic prn
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Next window: reseed at codeblock start, else shift in the feedback bit.
    always_comb begin
        lfsr_d = lfsr_q;
        if (init) begin
            lfsr_d = PRN_SEED;
        end else if (advance) begin
            lfsr_d = {lfsr_q[6:0], ^(lfsr_q & PRN_TAPS)};
        end
    end

    // Sequence register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= PRN_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign prn = lfsr_q[7];

endmodule

// File: rtl/ccsds_asm_randomizer.sv
// Prefixes each 1-bit LDPC codeblock with the ASM, optionally randomizes it,
// checks length against tlast. Optional randomizer: CCSDS_RANDOMIZER_EN.
module ccsds_asm_randomizer
    import ccsds_tm_pkg::*;
#(
    parameter logic [31:0] ASM_WORD  = ASM_WORD_DEFAULT,
    parameter int          BLOCK_LEN = BLOCK_LEN_LDPC_8160
) (
    input  logic clk,
    input  logic rst,
    input  logic s_axis_tdata,
    input  logic s_axis_tvalid,
    input  logic s_axis_tlast,
    output logic s_axis_tready,
    output logic m_axis_tdata,
    output logic m_axis_tvalid,
    output logic m_axis_tlast,
    input  logic m_axis_tready,
    output logic frame_err
);

    localparam logic [12:0] LAST_IDX = 13'(BLOCK_LEN - 1);

    state_e      state_q, state_d;
    logic [4:0]  asm_cnt_q, asm_cnt_d;
    logic [12:0] bit_cnt_q, bit_cnt_d;
    logic        m_data_q, m_data_d;
    logic        m_valid_q, m_valid_d;
    logic        m_last_q, m_last_d;
    logic        err_q, err_d;
    logic        slot_free;
    logic        is_full;
    logic        lfsr_init;
    logic        lfsr_adv;
    logic        prn;

`ifdef CCSDS_RANDOMIZER_EN
    ccsds_prn_lfsr u_prn (
        .clk     (clk),
        .rst     (rst),
        .init    (lfsr_init),
        .advance (lfsr_adv),
        .prn     (prn)
    );
`else
    logic unused_lfsr;
    assign unused_lfsr = lfsr_init | lfsr_adv;
    assign prn         = 1'b0;
`endif

    assign slot_free = !m_valid_q || m_axis_tready;
    assign is_full   = (bit_cnt_q == LAST_IDX);

    // Framing FSM and output-slot loading.
    always_comb begin
        state_d       = state_q;
        asm_cnt_d     = asm_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        m_data_d      = m_data_q;
        m_valid_d     = m_valid_q;
        m_last_d      = m_last_q;
        err_d         = 1'b0;
        lfsr_init     = 1'b0;
        lfsr_adv      = 1'b0;
        s_axis_tready = 1'b0;
        if (slot_free) begin
            m_valid_d = 1'b0;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (s_axis_tvalid) begin
                    state_d   = ST_ASM;
                    asm_cnt_d = 5'd0;
                end
            end
            ST_ASM: begin
                if (slot_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = ASM_WORD[5'd31 - asm_cnt_q];
                    m_last_d  = 1'b0;
                    asm_cnt_d = asm_cnt_q + 5'd1;
                    if (asm_cnt_q == 5'd31) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 13'd0;
                        lfsr_init = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                s_axis_tready = slot_free;
                if (s_axis_tvalid && slot_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = s_axis_tdata ^ prn;
                    bit_cnt_d = bit_cnt_q + 13'd1;
                    lfsr_adv  = 1'b1;
                    m_last_d  = s_axis_tlast || is_full;
                    if (s_axis_tlast || is_full) begin
                        state_d = ST_IDLE;
                        err_d   = s_axis_tlast ^ is_full;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and the registered output slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            asm_cnt_q <= 5'd0;
            bit_cnt_q <= 13'd0;
            m_data_q  <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            asm_cnt_q <= asm_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            err_q     <= err_d;
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign frame_err     = err_q;

endmodule

// File: tb/tb_ccsds_asm_randomizer.sv
// Bench for ccsds_asm_randomizer: frame model from input bit stream,
// per-cycle output compare, directed framing/reset scenarios.
module tb_ccsds_asm_randomizer;

    localparam int          BL  = 8160;
    localparam logic [31:0] ASM = 32'h1ACFFC1D;
`ifdef CCSDS_RANDOMIZER_EN
    localparam bit RAND = 1'b1;
`else
    localparam bit RAND = 1'b0;
`endif
    localparam logic [31:0] PRN_W0 = RAND ? 32'hFF480EC0 : 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_axis_tdata = 1'b0;
    logic s_axis_tvalid = 1'b0;
    logic s_axis_tlast = 1'b0;
    logic s_axis_tready;
    logic m_axis_tdata;
    logic m_axis_tvalid;
    logic m_axis_tlast;
    logic m_axis_tready = 1'b1;
    logic frame_err;

    ccsds_asm_randomizer dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic d;
        logic l;
        logic e;
    } beat_t;

    beat_t expq[$];
    bit    prn[0:254];
    bit    m_in_frame = 1'b0;
    int    m_k = 0;
    bit    obs_d[0:16383];
    bit    obs_l[0:16383];
    int    obs_n = 0;
    int    errp = 0;
    int    first_v = 0;
    int    t_rise = 0;
    int    last_cyc = 0;
    int    rdy_mode = 0;
    int    gap_mode = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Spec-level framing model: ASM, then codeblock bits until tlast
    // or the block is full; mismatch between the two flags an error.
    task automatic model_push(input logic d, input logic l);
        logic full;
        logic fin;
        logic p;
        if (!m_in_frame) begin
            for (int i = 0; i < 32; i++)
                expq.push_back({ASM[31-i], 1'b0, 1'b0});
            m_k = 0;
            m_in_frame = 1'b1;
        end
        p    = RAND ? prn[m_k % 255] : 1'b0;
        full = (m_k == BL - 1);
        fin  = l || full;
        expq.push_back({d ^ p, fin, fin && (l != full)});
        m_k++;
        if (fin) m_in_frame = 1'b0;
    endtask

    task automatic model_reset();
        expq.delete();
        m_in_frame = 1'b0;
        m_k = 0;
    endtask

    function automatic logic [31:0] obs_word(input int s);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 32; i++) w = {w[30:0], obs_d[s+i]};
        return w;
    endfunction

    function automatic int first_last(input int s);
        for (int i = s; i < obs_n && i < 16384; i++)
            if (obs_l[i]) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        #1;
        m_axis_tready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    bit    prev_hold = 1'b0;
    logic  prev_d, prev_l;
    beat_t fr;
    logic  exp_err;

    // Output compare, mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (m_axis_tvalid && first_v < 0) first_v = cyc;
            if (prev_hold) begin
                chk("hold_valid", m_axis_tvalid, 1'b1);
                chk("hold_data", m_axis_tdata, prev_d);
                chk("hold_last", m_axis_tlast, prev_l);
            end
            if (m_axis_tvalid && expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_beat: got unexpected valid beat");
            end
            exp_err = (m_axis_tvalid && !prev_hold && expq.size() > 0)
                      ? expq[0].e : 1'b0;
            chk("frame_err", frame_err, exp_err);
            if (frame_err) errp++;
            if (m_axis_tvalid && m_axis_tready && expq.size() > 0) begin
                fr = expq.pop_front();
                chk("data", m_axis_tdata, fr.d);
                chk("last", m_axis_tlast, fr.l);
                if (obs_n < 16384) begin
                    obs_d[obs_n] = m_axis_tdata;
                    obs_l[obs_n] = m_axis_tlast;
                end
                obs_n++;
                if (m_axis_tlast) last_cyc = cyc;
            end
            prev_hold = m_axis_tvalid && !m_axis_tready;
            prev_d = m_axis_tdata;
            prev_l = m_axis_tlast;
        end
    end

    task automatic send_bit(input logic d, input logic l);
        bit acc;
        if (gap_mode != 0 && $urandom_range(0, 7) == 0) begin
            s_axis_tvalid = 1'b0;
            @(posedge clk);
            #1;
        end
        model_push(d, l);
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        if (t_rise < 0) t_rise = cyc;
        acc = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (s_axis_tready) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: got no tready expected tready");
        end
    endtask

    task automatic end_block();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (expq.size() == 0 && !m_axis_tvalid) begin
                done = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     expq.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tready"}, s_axis_tready, 1'b0);
        chk({tag, "_tdata"}, m_axis_tdata, 1'b0);
        chk({tag, "_tvalid"}, m_axis_tvalid, 1'b0);
        chk({tag, "_tlast"}, m_axis_tlast, 1'b0);
        chk({tag, "_ferr"}, frame_err, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pw;
        for (int n = 0; n < 8; n++) prn[n] = 1'b1;
        for (int n = 8; n < 255; n++)
            prn[n] = prn[n-1] ^ prn[n-3] ^ prn[n-5] ^ prn[n-8];
        pw = '0;
        for (int n = 0; n < 64; n++) pw = {pw[62:0], prn[n]};
        chk("prn_model_pin", pw, 64'hFF480EC09A0D70BC);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst0");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Full zero block, tready high
        first_v = -1;
        t_rise  = -1;
        obs_n   = 0;
        errp    = 0;
        for (int i = 0; i < BL; i++) send_bit(1'b0, i == BL - 1);
        end_block();
        drain();
        chk("t2_latency", first_v - t_rise, 2);
        chk("t2_span", last_cyc - first_v, 8191);
        chk("t2_asm", obs_word(0), ASM);
        chk("t2_prn", obs_word(32), PRN_W0);
        chk("t2_lastidx", first_last(0), 8191);
        chk("t2_count", obs_n, 8192);
        chk("t2_err", errp, 0);

        // Random backpressure and input gaps over 3 blocks
        rdy_mode = 1;
        gap_mode = 1;
        errp = 0;
        begin
            int lens[3] = '{BL, 2500, 4000};
            for (int b = 0; b < 3; b++) begin
                for (int i = 0; i < lens[b]; i++)
                    send_bit(1'($urandom_range(0, 1)), i == lens[b] - 1);
                end_block();
            end
        end
        drain();
        chk("t3_err", errp, 2);
        rdy_mode = 0;
        gap_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Early tlast on input bit 99, twice
        obs_n = 0;
        errp  = 0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 100; i++) send_bit(1'b0, i == 99);
        end_block();
        drain();
        chk("t4_last1", first_last(0), 131);
        chk("t4_asm2", obs_word(132), ASM);
        chk("t4_prn2", obs_word(164), PRN_W0);
        chk("t4_last2", first_last(132), 263);
        chk("t4_err", errp, 2);

        // Missing tlast across 8200 bits
        obs_n = 0;
        errp  = 0;
        for (int i = 0; i < 8200; i++) send_bit(1'b0, 1'b0);
        end_block();
        drain();
        chk("t5_forced_last", first_last(0), 8191);
        chk("t5_new_asm", obs_word(8192), ASM);
        chk("t5_new_prn", obs_word(8224), PRN_W0);
        chk("t5_count", obs_n, 8264);
        chk("t5_err", errp, 1);

        // Reset mid-DATA at bit 4000
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4000; i++)
            send_bit(1'($urandom_range(0, 1)), 1'b0);
        end_block();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check_reset_outputs("rst1");
        @(posedge clk);
        #1;
        rst = 1'b0;
        obs_n = 0;
        errp  = 0;
        for (int i = 0; i < 64; i++) send_bit(1'b0, i == 63);
        end_block();
        drain();
        chk("t6_asm", obs_word(0), ASM);
        chk("t6_prn", obs_word(32), PRN_W0);
        chk("t6_last", first_last(0), 95);
        chk("t6_err", errp, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
